// File: rtl/rx_commit_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : rx_commit_ctrl
// Description : Pairs each aggregated 44-bit receive payload word with the FCS
//               verdict of the same frame. Either event may arrive first. The
//               word is forwarded over a valid/ready handshake only when the
//               verdict is a pass. Failed, orphaned, overrun and timed-out
//               frames are dropped. Saturating statistics counters record the
//               outcome of each frame.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters:
//   TIMEOUT_CYCLES : cycles to wait for the missing half of a data/verdict pair
//   CNT_W          : width of each statistics counter (>= 2)
// Ports:
//   clk      in   eth_refclk domain clock
//   rstn     in   asynchronous active-low reset
//   en       in   enable; when low, data and verdict events are ignored
//   axiiv    in   payload word valid (single-cycle pulse)
//   axiid    in   44-bit payload word
//   ck_done  in   checksum verdict strobe (single-cycle pulse)
//   ck_kill  in   FCS failed, qualified by ck_done
//   axiov    out  committed word valid
//   axiod    out  committed word (registered)
//   axiir    in   downstream ready
//   good_cnt out  frames delivered
//   drop_cnt out  frames dropped (FCS fail, overrun, busy, data timeout)
//   tmo_cnt  out  pairing timeouts
//==============================================================================
module rx_commit_ctrl #(
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             axiiv,
    input  logic [43:0]      axiid,
    input  logic             ck_done,
    input  logic             ck_kill,
    output logic             axiov,
    output logic [43:0]      axiod,
    input  logic             axiir,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] tmo_cnt
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_HAVE_DATA = 2'd1;
    localparam logic [1:0] c_ST_HAVE_VERD = 2'd2;
    localparam logic [1:0] c_ST_PRESENT   = 2'd3;

    localparam int c_TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [43:0]        r_data;
    logic [c_TMR_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_good_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [CNT_W-1:0]   r_tmo_cnt;

    logic       w_d;
    logic       w_p;
    logic       w_f;
    logic       w_tmo_hit;
    logic       w_load;
    logic       w_tmr_clr;
    logic       w_good_inc;
    logic       w_tmo_inc;
    logic [1:0] w_drop_inc;

    assign w_d       = axiiv & en;
    assign w_p       = ck_done & ~ck_kill & en;
    assign w_f       = ck_done & ck_kill & en;
    assign w_tmo_hit = (r_timer == c_TMR_LAST);

    // Saturating add; the increment never exceeds 2.
    function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] v,
                                                   input logic [1:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, v} + (CNT_W+1)'(inc);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and event decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_tmr_clr   = 1'b0;
        w_good_inc  = 1'b0;
        w_tmo_inc   = 1'b0;
        w_drop_inc  = 2'd0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_d && w_p) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_PRESENT;
                end else if (w_d && w_f) begin
                    w_drop_inc  = 2'd1;
                end else if (w_d) begin
                    w_load      = 1'b1;
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = c_ST_HAVE_DATA;
                end else if (w_p) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = c_ST_HAVE_VERD;
                end else if (w_f) begin
                    w_drop_inc  = 2'd1;
                end
            end
            c_ST_HAVE_DATA: begin
                if (w_d) begin
                    // Overrun: the buffered word is lost, a same-cycle verdict
                    // belongs to the new word.
                    w_load = 1'b1;
                    if (w_p) begin
                        w_drop_inc  = 2'd1;
                        w_state_nxt = c_ST_PRESENT;
                    end else if (w_f) begin
                        w_drop_inc  = 2'd2;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_drop_inc  = 2'd1;
                        w_tmr_clr   = 1'b1;
                    end
                end else if (w_p) begin
                    w_state_nxt = c_ST_PRESENT;
                end else if (w_f) begin
                    w_drop_inc  = 2'd1;
                    w_state_nxt = c_ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_tmo_inc   = 1'b1;
                    w_drop_inc  = 2'd1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_HAVE_VERD: begin
                if (w_d && w_f) begin
                    // A fresh fail verdict supersedes the orphan and kills the word.
                    w_drop_inc  = 2'd1;
                    w_state_nxt = c_ST_IDLE;
                end else if (w_d) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_PRESENT;
                end else if (w_f) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_p) begin
                    w_tmr_clr   = 1'b1;
                end else if (w_tmo_hit) begin
                    w_tmo_inc   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin // c_ST_PRESENT
                if (w_d) begin
                    w_drop_inc = 2'd1;
                end
                if (axiir) begin
                    w_good_inc  = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Outputs: valid follows the state register, data is a held register.
    //--------------------------------------------------------------------------
    always_comb begin
        axiov = (r_state == c_ST_PRESENT);
    end

    assign axiod    = r_data;
    assign good_cnt = r_good_cnt;
    assign drop_cnt = r_drop_cnt;
    assign tmo_cnt  = r_tmo_cnt;

    //--------------------------------------------------------------------------
    // Datapath: word buffer, pairing timer, statistics
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= axiid;
        end
    end

    // The timer only matters while waiting for the other half of a pair; it is
    // parked at zero in IDLE and PRESENT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_timer <= '0;
        end else if (w_tmr_clr ||
                     (w_state_nxt != c_ST_HAVE_DATA && w_state_nxt != c_ST_HAVE_VERD)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_good_cnt <= '0;
            r_drop_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_good_cnt <= f_sat_add(r_good_cnt, {1'b0, w_good_inc});
            r_drop_cnt <= f_sat_add(r_drop_cnt, w_drop_inc);
            r_tmo_cnt  <= f_sat_add(r_tmo_cnt, {1'b0, w_tmo_inc});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_commit_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_rx_commit_ctrl
// Description : Scoreboard bench for rx_commit_ctrl. Stimulus pushes the words
//               that must be delivered; a monitor pops them at each handshake
//               and checks that a stalled output stays stable.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_rx_commit_ctrl;

    localparam int c_TMO = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        axiiv;
    logic [43:0] axiid;
    logic        ck_done;
    logic        ck_kill;
    logic        axiir;
    logic        axiov;
    logic [43:0] axiod;
    logic [15:0] good_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] tmo_cnt;
    logic        s_axiov;
    logic [43:0] s_axiod;
    logic [3:0]  s_good_cnt;
    logic [3:0]  s_drop_cnt;
    logic [3:0]  s_tmo_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [43:0] sb_q[$];

    always #5 clk = ~clk;

    rx_commit_ctrl #(.TIMEOUT_CYCLES(c_TMO), .CNT_W(16)) u_dut (
        .clk(clk), .rstn(rstn), .en(en), .axiiv(axiiv), .axiid(axiid),
        .ck_done(ck_done), .ck_kill(ck_kill), .axiov(axiov), .axiod(axiod),
        .axiir(axiir), .good_cnt(good_cnt), .drop_cnt(drop_cnt), .tmo_cnt(tmo_cnt)
    );

    rx_commit_ctrl #(.TIMEOUT_CYCLES(c_TMO), .CNT_W(4)) u_sat (
        .clk(clk), .rstn(rstn), .en(en), .axiiv(axiiv), .axiid(axiid),
        .ck_done(ck_done), .ck_kill(ck_kill), .axiov(s_axiov), .axiod(s_axiod),
        .axiir(axiir), .good_cnt(s_good_cnt), .drop_cnt(s_drop_cnt), .tmo_cnt(s_tmo_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: handshake pops the scoreboard; a stall must hold valid and data.
    logic        m_stall = 1'b0;
    logic [43:0] m_word  = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            m_stall = 1'b0;
        end else begin
            if (m_stall) begin
                check("stall_valid", {63'd0, axiov}, 64'd1);
                check("stall_data", {20'd0, axiod}, {20'd0, m_word});
            end
            if (axiov && axiir) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", {20'd0, axiod}, 64'hDEAD);
                end else begin
                    check("delivered_word", {20'd0, axiod}, {20'd0, sb_q.pop_front()});
                end
            end
            m_stall = axiov && !axiir;
            m_word  = axiod;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_d(input logic [43:0] w);
        axiiv = 1'b1;
        axiid = w;
        tick();
        axiiv = 1'b0;
    endtask

    task automatic pulse_v(input logic kill);
        ck_done = 1'b1;
        ck_kill = kill;
        tick();
        ck_done = 1'b0;
        ck_kill = 1'b0;
    endtask

    task automatic pulse_dv(input logic [43:0] w, input logic kill);
        axiiv   = 1'b1;
        axiid   = w;
        ck_done = 1'b1;
        ck_kill = kill;
        tick();
        axiiv   = 1'b0;
        ck_done = 1'b0;
        ck_kill = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; en = 1'b1; axiiv = 1'b0; axiid = '0;
        ck_done = 1'b0; ck_kill = 1'b0; axiir = 1'b1;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Reset state
        check("rst_axiov", {63'd0, axiov}, 64'd0);
        check("rst_axiod", {20'd0, axiod}, 64'd0);
        check("rst_good", {48'd0, good_cnt}, 64'd0);
        check("rst_drop", {48'd0, drop_cnt}, 64'd0);
        check("rst_tmo", {48'd0, tmo_cnt}, 64'd0);

        // Data then pass verdict, ready high
        repeat (5) tick();
        sb_q.push_back(44'h0AB_CDEF_1234);
        pulse_d(44'h0AB_CDEF_1234);
        repeat (4) tick();
        check("dtv_wait_axiov", {63'd0, axiov}, 64'd0);
        pulse_v(1'b0);
        check("dtv_axiov", {63'd0, axiov}, 64'd1);
        tick();
        check("dtv_axiov_fall", {63'd0, axiov}, 64'd0);
        check("dtv_good", {48'd0, good_cnt}, 64'd1);
        check("dtv_drop", {48'd0, drop_cnt}, 64'd0);

        // Verdict then data under a 20-cycle stall, busy drop during stall
        axiir = 1'b0;
        pulse_v(1'b0);
        repeat (3) tick();
        sb_q.push_back(44'h123);
        pulse_d(44'h123);
        check("vtd_axiov", {63'd0, axiov}, 64'd1);
        repeat (5) tick();
        pulse_d(44'hBAD);
        repeat (14) tick();
        check("vtd_busy_drop", {48'd0, drop_cnt}, 64'd1);
        check("vtd_hold_good", {48'd0, good_cnt}, 64'd1);
        axiir = 1'b1;
        tick();
        check("vtd_good", {48'd0, good_cnt}, 64'd2);

        // Data and pass verdict in the same cycle, stalled
        axiir = 1'b0;
        sb_q.push_back(44'h0F0_F0F0_F0F0);
        pulse_dv(44'h0F0_F0F0_F0F0, 1'b0);
        check("same_axiov", {63'd0, axiov}, 64'd1);
        repeat (20) tick();
        axiir = 1'b1;
        tick();
        check("same_good", {48'd0, good_cnt}, 64'd3);
        check("same_drop", {48'd0, drop_cnt}, 64'd1);

        // FCS fail: data then fail, and data with fail in one cycle
        pulse_d(44'h111);
        tick();
        pulse_v(1'b1);
        pulse_dv(44'h112, 1'b1);
        repeat (3) tick();
        check("fcs_axiov", {63'd0, axiov}, 64'd0);
        check("fcs_drop", {48'd0, drop_cnt}, 64'd3);
        check("fcs_good", {48'd0, good_cnt}, 64'd3);

        // Data with no verdict: timeout exactly 16 cycles after the data
        pulse_d(44'h222);
        repeat (15) tick();
        check("tmo_early", {48'd0, tmo_cnt}, 64'd0);
        tick();
        check("tmo_fired", {48'd0, tmo_cnt}, 64'd1);
        check("tmo_drop", {48'd0, drop_cnt}, 64'd4);

        // Pass verdict on the last timer cycle wins over the timeout
        sb_q.push_back(44'h333);
        pulse_d(44'h333);
        repeat (15) tick();
        pulse_v(1'b0);
        check("tmo_edge_axiov", {63'd0, axiov}, 64'd1);
        check("tmo_edge_tmo", {48'd0, tmo_cnt}, 64'd1);
        tick();
        check("tmo_edge_good", {48'd0, good_cnt}, 64'd4);

        // Overrun: second word wins
        pulse_d(44'h444);
        sb_q.push_back(44'h555);
        pulse_d(44'h555);
        pulse_v(1'b0);
        tick();
        check("ovr_good", {48'd0, good_cnt}, 64'd5);
        check("ovr_drop", {48'd0, drop_cnt}, 64'd5);

        // Enable low masks events
        en = 1'b0;
        pulse_dv(44'h666, 1'b0);
        tick();
        check("en_axiov", {63'd0, axiov}, 64'd0);
        check("en_drop", {48'd0, drop_cnt}, 64'd5);
        en = 1'b1;

        // Asynchronous reset while presenting
        axiir = 1'b0;
        pulse_dv(44'h777, 1'b0);
        check("arst_pre_axiov", {63'd0, axiov}, 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_axiov", {63'd0, axiov}, 64'd0);
        check("arst_axiod", {20'd0, axiod}, 64'd0);
        check("arst_good", {48'd0, good_cnt}, 64'd0);
        check("arst_drop", {48'd0, drop_cnt}, 64'd0);
        check("arst_tmo", {48'd0, tmo_cnt}, 64'd0);
        @(negedge clk);
        rstn  = 1'b1;
        axiir = 1'b1;
        tick();

        // Saturation: 20 fails on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            pulse_v(1'b1);
        end
        tick();
        check("sat_drop4", {60'd0, s_drop_cnt}, 64'd15);
        check("sat_drop16", {48'd0, drop_cnt}, 64'd20);

        repeat (2) tick();
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
